// File: rtl/bcd_counter_ctrl.sv
// Run/pause/lap/clear sequencer for the two-digit BCD counter: button conditioning,
// four-state control FSM, count-step prescaler and lap display mux.
module bcd_counter_ctrl #(
   parameter int DIV         = 50,
   parameter bit STOP_AT_MAX = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clr,
   input  logic [7:0] count_in,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic [7:0] disp,
   output logic       running,
   output logic       frozen,
   output logic [1:0] state
);

   localparam int               PRE_W    = $clog2(DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   state_t           state_q;
   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic [7:0]       lap_q;
   logic             cnt_clr_q;
   logic [2:0]       sync1_q;
   logic [2:0]       sync2_q;
   logic [2:0]       low_q;
   logic [1:0]       vld_q;
   logic [2:0]       ev;
   logic             ev_clr;
   logic             ev_start;
   logic             ev_lap;
   logic             active;
   logic             step;
   logic             auto_stop;

   // Button bits are {clr, lap, start}. low_q records a genuine low sample on the
   // previous edge; it stays clear until the synchronizer holds post-reset samples,
   // so a button held through reset is not mistaken for a fresh press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         low_q   <= '0;
         vld_q   <= '0;
      end else begin
         sync1_q <= {btn_clr, btn_lap, btn_start};
         sync2_q <= sync1_q;
         low_q   <= {3{vld_q[1]}} & ~sync2_q;
         vld_q   <= {vld_q[0], 1'b1};
      end
   end

   assign ev       = sync2_q & low_q;
   assign ev_clr   = ev[2];
   assign ev_start = ev[0] & ~ev[2];
   assign ev_lap   = ev[1] & ~ev[0] & ~ev[2];

   assign active    = (state_q == RUN) || (state_q == LAP);
   assign step      = active && (pre_q == PRE_LAST);
   assign auto_stop = STOP_AT_MAX && step && (count_in == 8'h99);
   assign pre_d     = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pre_q     <= '0;
         lap_q     <= 8'h00;
         cnt_clr_q <= 1'b0;
      end else begin
         cnt_clr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               pre_q <= '0;
               if (ev_clr) begin
                  cnt_clr_q <= 1'b1;
               end else if (ev_start) begin
                  state_q <= RUN;
               end
            end
            RUN, LAP: begin
               pre_q <= pre_d;
               // An auto-stop swallows a coincident start press rather than toggling twice.
               if (auto_stop || ev_start) begin
                  state_q <= PAUSE;
               end else if (ev_lap) begin
                  if (state_q == RUN) begin
                     state_q <= LAP;
                     lap_q   <= count_in;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            PAUSE: begin
               if (ev_clr) begin
                  state_q   <= IDLE;
                  pre_q     <= '0;
                  cnt_clr_q <= 1'b1;
               end else if (ev_start) begin
                  state_q <= RUN;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cnt_en  = step && !auto_stop;
   assign cnt_clr = cnt_clr_q;
   assign running = active;
   assign frozen  = (state_q == LAP);
   assign state   = state_q;
   assign disp    = frozen ? lap_q : count_in;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Scoreboard bench for bcd_counter_ctrl (DIV=4): one instance wraps at 99, one auto-stops,
// each looped through a BCD counter and compared every cycle with a decimal-count model.
module tb_bcd_counter_ctrl;
   localparam int DIV = 4;

   logic       clk       = 1'b0;
   logic       reset     = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_lap   = 1'b0;
   logic       btn_clr   = 1'b0;
   logic       rst_nxt   = 1'b0;
   logic [7:0] cnt_w, cnt_s;
   logic       en_w, clr_w, run_w, frz_w;
   logic       en_s, clr_s, run_s, frz_s;
   logic [7:0] disp_w, disp_s;
   logic [1:0] st_w, st_s;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   bcd_counter_ctrl #(.DIV(DIV), .STOP_AT_MAX(1'b0)) dut_w (
      .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
      .count_in(cnt_w), .cnt_en(en_w), .cnt_clr(clr_w), .disp(disp_w),
      .running(run_w), .frozen(frz_w), .state(st_w));

   bcd_counter_ctrl #(.DIV(DIV), .STOP_AT_MAX(1'b1)) dut_s (
      .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
      .count_in(cnt_s), .cnt_en(en_s), .cnt_clr(clr_s), .disp(disp_s),
      .running(run_s), .frozen(frz_s), .state(st_s));

   function automatic logic [7:0] bcd_of(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   function automatic int val_of(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   // The external two-digit BCD counter that each controller drives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_w <= 8'h00;
         cnt_s <= 8'h00;
      end else begin
         if (clr_w) cnt_w <= 8'h00;
         else if (en_w) cnt_w <= bcd_of((val_of(cnt_w) + 1) % 100);
         if (clr_s) cnt_s <= 8'h00;
         else if (en_s) cnt_s <= bcd_of((val_of(cnt_s) + 1) % 100);
      end
   end

   typedef struct packed {
      logic [1:0] st;
      logic       en;
      logic       clr;
      logic       run;
      logic       frz;
      logic [7:0] disp;
   } obs_t;

   typedef struct packed {
      obs_t w;
      obs_t s;
   } pair_t;

   pair_t expq[$];

   // Reference model: index 0 wraps, index 1 auto-stops. Counts kept as decimal integers.
   int m_st[2];
   int m_ph[2];
   int m_cnt[2];
   int m_lap[2];
   bit m_clr[2];
   int hist[3][3];

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         m_st[m] = 0; m_ph[m] = 0; m_cnt[m] = 0; m_lap[m] = 0; m_clr[m] = 1'b0;
      end
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) hist[i][j] = -1;
   endfunction

   function automatic obs_t model_obs(input int m);
      obs_t o;
      o.st   = 2'(m_st[m]);
      o.run  = (m_st[m] == 1) || (m_st[m] == 3);
      o.frz  = (m_st[m] == 3);
      o.en   = o.run && (m_ph[m] == DIV - 1) && !((m == 1) && (m_cnt[m] == 99));
      o.clr  = m_clr[m];
      o.disp = o.frz ? bcd_of(m_lap[m]) : bcd_of(m_cnt[m]);
      return o;
   endfunction

   function automatic void model_edge();
      bit   evb[3];
      bit   e_clr, e_start, e_lap, act, stop;
      int   nst, nph, ncnt;
      obs_t o;
      logic [2:0] b;
      b = {btn_clr, btn_lap, btn_start};
      // A press is a sample of 1 two edges back that followed a real sample of 0.
      for (int i = 0; i < 3; i++) evb[i] = (hist[i][1] == 1) && (hist[i][2] == 0);
      e_clr   = evb[2];
      e_start = evb[0] && !e_clr;
      e_lap   = evb[1] && !evb[0] && !evb[2];
      for (int m = 0; m < 2; m++) begin
         o    = model_obs(m);
         act  = o.run;
         stop = (m == 1) && act && (m_ph[m] == DIV - 1) && (m_cnt[m] == 99);
         ncnt = m_clr[m] ? 0 : (o.en ? (m_cnt[m] + 1) % 100 : m_cnt[m]);
         nph  = act ? (m_ph[m] + 1) % DIV : ((m_st[m] == 2) ? m_ph[m] : 0);
         nst  = m_st[m];
         m_clr[m] = 1'b0;
         if (m_st[m] == 0) begin
            if (e_clr) m_clr[m] = 1'b1;
            else if (e_start) nst = 1;
         end else if (m_st[m] == 2) begin
            if (e_clr) begin nst = 0; nph = 0; m_clr[m] = 1'b1; end
            else if (e_start) nst = 1;
         end else begin
            if (stop || e_start) nst = 2;
            else if (e_lap && m_st[m] == 1) begin nst = 3; m_lap[m] = m_cnt[m]; end
            else if (e_lap) nst = 1;
         end
         m_st[m] = nst; m_ph[m] = nph; m_cnt[m] = ncnt;
      end
      for (int i = 0; i < 3; i++) begin
         hist[i][2] = hist[i][1];
         hist[i][1] = hist[i][0];
         hist[i][0] = int'(b[i]);
      end
   endfunction

   function automatic void push_exp();
      pair_t p;
      p.w = model_obs(0);
      p.s = model_obs(1);
      expq.push_back(p);
   endfunction

   function automatic void chk(input string name, input logic [7:0] got, input logic [7:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endfunction

   function automatic void check_obs(input string tag, input obs_t want, input obs_t got);
      chk({tag, ".state"},   8'(got.st),  8'(want.st));
      chk({tag, ".cnt_en"},  8'(got.en),  8'(want.en));
      chk({tag, ".cnt_clr"}, 8'(got.clr), 8'(want.clr));
      chk({tag, ".running"}, 8'(got.run), 8'(want.run));
      chk({tag, ".frozen"},  8'(got.frz), 8'(want.frz));
      chk({tag, ".disp"},    got.disp,    want.disp);
   endfunction

   pair_t mon_e;
   always @(negedge clk) begin
      if (expq.size() != 0) begin
         mon_e = expq.pop_front();
         check_obs("wrap", mon_e.w, {st_w, en_w, clr_w, run_w, frz_w, disp_w});
         check_obs("stop", mon_e.s, {st_s, en_s, clr_s, run_s, frz_s, disp_s});
      end
   end

   task automatic cyc(input logic [2:0] b);
      @(negedge clk);
      btn_start = b[0];
      btn_lap   = b[1];
      btn_clr   = b[2];
      reset     = rst_nxt;
      @(posedge clk);
      if (reset) model_edge();
      push_exp();
   endtask

   task automatic run(input int n);
      repeat (n) cyc(3'b000);
   endtask

   task automatic press(input logic [2:0] b, input int hold);
      repeat (hold) cyc(b);
      cyc(3'b000);
   endtask

   // Called just after a rising edge: drops reset mid-cycle, with no edge before the check.
   task automatic async_reset();
      #2;
      reset   = 1'b0;
      rst_nxt = 1'b0;
      model_reset();
      expq.delete();
      push_exp();
   endtask

   initial begin
      int guard;
      logic [2:0] rb;
      model_reset();
      cyc(3'b000);
      cyc(3'b000);
      rst_nxt = 1'b1;
      run(3);

      press(3'b001, 2);
      run(16);

      // Pause so that the held prescaler value is 2, then resume.
      guard = 0;
      while (m_ph[0] != 3 && guard < 10) begin cyc(3'b000); guard++; end
      press(3'b001, 1);
      run(6);
      press(3'b001, 1);
      run(10);

      guard = 0;
      while (m_cnt[0] % 10 != 5 && guard < 200) begin cyc(3'b000); guard++; end
      press(3'b010, 1);
      run(14);
      press(3'b010, 1);
      run(6);

      press(3'b100, 1);
      run(4);
      press(3'b001, 1);
      run(3);
      press(3'b100, 1);
      run(4);
      press(3'b001, 1);
      run(5);
      press(3'b001, 1);
      run(3);
      press(3'b111, 1);
      run(4);

      // Run up to 99: the stopping instance pauses, the wrapping one rolls over.
      press(3'b001, 1);
      guard = 0;
      while (m_st[1] != 2 && guard < 1000) begin cyc(3'b000); guard++; end
      if (guard >= 1000) begin
         n_total++; n_bad++;
         $display("FAIL autostop_wait: got no pause want pause within 1000 cycles");
      end
      run(12);

      press(3'b010, 1);
      run(3);
      async_reset();
      cyc(3'b001);
      cyc(3'b001);
      rst_nxt = 1'b1;
      repeat (10) cyc(3'b001);
      run(5);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            async_reset();
            repeat ($urandom_range(1, 3)) cyc(3'($urandom_range(0, 7)));
            rst_nxt = 1'b1;
         end
         rb[0] = ($urandom_range(0, 9) == 0);
         rb[1] = ($urandom_range(0, 11) == 0);
         rb[2] = ($urandom_range(0, 19) == 0);
         cyc(rb);
      end
      run(4);

      guard = 0;
      while (expq.size() != 0 && guard < 5) begin @(negedge clk); #1; guard++; end
      if (expq.size() != 0) begin
         n_total++; n_bad++;
         $display("FAIL drain: got %0d pending want 0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
